heap_cell_writer: RTL
=====================

Name: heap_cell_writer

Overview:
Writes Lisp cells into the writable heap RAM, one word per cycle. It is the write-side counterpart of the block-ROM cell image. The layout matches the ROM image: the tag word is at the cell address and payload words follow at consecutive addresses. The block bump-allocates from a free pointer and returns the new cell's address, so the evaluator can build cons/number/primitive cells at run time.

Parameters:
ADDR_WIDTH, 8, heap address width
DATA_WIDTH, 8, heap word width
HEAP_BASE, 'h1C, first allocatable address (first word after the constant ROM image)
HEAP_LIMIT, (1<<ADDR_WIDTH)-1, last allocatable address (inclusive)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  allocation request present
req_ready  out  1  block can accept a request
req_tag  in  DATA_WIDTH  cell type tag (lisp::TYPE_*)
req_w0  in  DATA_WIDTH  payload word 0 (number value / car / prim id)
req_w1  in  DATA_WIDTH  payload word 1 (cdr / NIL)
req_w2  in  DATA_WIDTH  payload word 2 (NIL for prim)
resp_valid  out  1  one-cycle completion pulse
resp_addr  out  ADDR_WIDTH  address of new cell's tag word; lisp::NIL on error
resp_err  out  2  0 OK, 1 out-of-memory, 2 bad tag
mem_we  out  1  heap RAM write enable
mem_addr  out  ADDR_WIDTH  heap RAM write address
mem_wdata  out  DATA_WIDTH  heap RAM write data
free_ptr  out  ADDR_WIDTH  next free heap address

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_addr=NIL; resp_err=0; mem_we=0; mem_addr=0; mem_wdata=0; free_ptr=HEAP_BASE.
- Cell length in words, including the tag:
  - TYPE_NUMBER: 2 words (tag, w0).
  - TYPE_CONS: 3 words (tag, w0, w1).
  - TYPE_FUNC_PRIM: 4 words (tag, w0, w1, w2).
  - Any other tag: bad tag.
- Handshake: a request is accepted on the posedge where req_valid && req_ready. Tag and payload are latched at that edge. req_ready=1 only in IDLE.
- FSM states are IDLE, WRITE, RESP.
- IDLE -> on accept:
  - If the tag is bad: go to RESP with err=2, no writes.
  - Else if free_ptr + len > HEAP_LIMIT + 1: go to RESP with err=1, no writes. The comparison is computed at ADDR_WIDTH+1 bits, so wrap-around can never pass the check.
  - Otherwise: base = free_ptr; go to WRITE with index k=0.
- WRITE:
  - Each cycle mem_we=1, mem_addr=base+k, mem_wdata = {tag, w0, w1, w2}[k].
  - k increments each cycle. After k=len-1, go to RESP.
  - Words are written in ascending address order, tag first.
- RESP (exactly one cycle):
  - resp_valid=1.
  - resp_addr=base on success, NIL on error.
  - On success, free_ptr becomes base+len at the transition into RESP, so it is visible in the RESP cycle. On error, free_ptr is unchanged.
  - Next state is IDLE.
- Latency: the first write occurs in the cycle after the accept edge. resp_valid is high len+1 cycles after the accept edge on success, and 1 cycle after on error.
- Minimum request spacing is len+2 cycles; back-to-back requests need no idle gap beyond that.
- mem_we is never asserted outside WRITE. Addresses never exceed HEAP_LIMIT.
- An exact fit (free_ptr + len == HEAP_LIMIT + 1) succeeds. The next request of any valid type then returns OOM.
- req_valid held high during WRITE/RESP is ignored and not double-accepted. Payload inputs may change freely after the accept edge.
- Reset mid-WRITE: mem_we drops on the reset edge, free_ptr returns to HEAP_BASE, and no resp_valid is issued. The partial cell is abandoned.

Decomposition:
- Shared lisp package:
  - Cell-length constants CELL_LEN_NUMBER=2, CELL_LEN_CONS=3, CELL_LEN_FUNC_PRIM=4.
  - A function cell_len(tag) returning 0 for bad tags.
  - The resp_err enum (ERR_NONE, ERR_OOM, ERR_BAD_TAG).
- The FSM state enum stays local to the module.
- No sub-module: the heap RAM is instantiated by the parent and driven through the mem_* ports.

Test Plan:
- Cons after reset: tag=TYPE_CONS, w0='h3, w1=NIL -> writes [1C]=TYPE_CONS, [1D]=3, [1E]=NIL in 3 consecutive cycles; resp_addr='h1C, err=0; free_ptr='h1F.
- Number then func-prim back-to-back: NUMBER w0='h56, then FUNC_PRIM w0=TYPE_PRIM_CAR -> number at 'h1F (2 writes), prim at 'h21 (4 writes, last two NIL); free_ptr='h25.
- Exact fit and OOM: with HEAP_LIMIT='h1E, cons at 'h1C succeeds with free_ptr='h1F. A following NUMBER -> resp_err=1, resp_addr=NIL, zero mem_we cycles, free_ptr unchanged.
- Bad tag: req_tag='hFF -> resp_valid one cycle after accept, err=2, no writes.
- Reset mid-write: assert rst on the 2nd WRITE cycle of a cons -> mem_we=0 next cycle, no resp_valid, free_ptr='h1C, req_ready=1.
- Handshake: req_valid held high for 10 cycles -> exactly two accepts (cons: accept, 3 writes, resp, accept). Verify req_ready low throughout WRITE/RESP.

Source files
------------

// File: rtl/heap_cell_writer_pkg.sv
// Shared Lisp cell definitions: type tags, NIL, cell lengths
// and the allocation error codes returned by the heap writer.
package heap_cell_writer_pkg;

   localparam int TAG_W = 8;

   localparam logic [TAG_W-1:0] NIL            = 8'h00;
   localparam logic [TAG_W-1:0] TYPE_NUMBER    = 8'h01;
   localparam logic [TAG_W-1:0] TYPE_CONS      = 8'h02;
   localparam logic [TAG_W-1:0] TYPE_FUNC_PRIM = 8'h03;
   localparam logic [TAG_W-1:0] TYPE_PRIM_CAR  = 8'h10;

   localparam logic [2:0] CELL_LEN_NUMBER    = 3'd2;
   localparam logic [2:0] CELL_LEN_CONS      = 3'd3;
   localparam logic [2:0] CELL_LEN_FUNC_PRIM = 3'd4;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_OOM     = 2'd1,
      ERR_BAD_TAG = 2'd2
   } err_e;

   // Zero length marks a tag the writer cannot lay out.
   function automatic logic [2:0] cell_len(
      input logic [TAG_W-1:0] tag
   );
      logic [2:0] len;
      len = 3'd0;
      unique case (1'b1)
         (tag == TYPE_NUMBER):    len = CELL_LEN_NUMBER;
         (tag == TYPE_CONS):      len = CELL_LEN_CONS;
         (tag == TYPE_FUNC_PRIM): len = CELL_LEN_FUNC_PRIM;
         default:                 len = 3'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/heap_cell_writer_if.sv
// Allocation request/response bundle between the evaluator
// (master) and the heap cell writer (slave).
interface heap_cell_writer_if
   import heap_cell_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);

   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_tag;
   logic [DATA_WIDTH-1:0] req_w0;
   logic [DATA_WIDTH-1:0] req_w1;
   logic [DATA_WIDTH-1:0] req_w2;
   logic                  resp_valid;
   logic [ADDR_WIDTH-1:0] resp_addr;
   err_e                  resp_err;

   modport master (
      output req_valid,
      output req_tag,
      output req_w0,
      output req_w1,
      output req_w2,
      input  req_ready,
      input  resp_valid,
      input  resp_addr,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_tag,
      input  req_w0,
      input  req_w1,
      input  req_w2,
      output req_ready,
      output resp_valid,
      output resp_addr,
      output resp_err
   );

endinterface

// File: rtl/heap_cell_writer.sv
// Bump-allocates Lisp cells in heap RAM and writes them one
// word per cycle, tag word first at the returned address.
module heap_cell_writer
   import heap_cell_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int HEAP_BASE  = 'h1C,
   parameter int HEAP_LIMIT = (1 << ADDR_WIDTH) - 1
) (
   input  logic                  clk,
   input  logic                  rst,
   heap_cell_writer_if.slave     bus,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH-1:0] free_ptr
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RESP
   } state_e;

   localparam int AW1 = ADDR_WIDTH + 1;

   localparam logic [ADDR_WIDTH:0] LIMIT_P1 =
      AW1'(HEAP_LIMIT) + AW1'(1);
   localparam logic [ADDR_WIDTH:0] BASE_X =
      AW1'(HEAP_BASE);
   localparam logic [ADDR_WIDTH-1:0] NIL_A =
      ADDR_WIDTH'(NIL);

   state_e                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [2:0]            len;
   logic [2:0]            k;
   logic [DATA_WIDTH-1:0] w0;
   logic [DATA_WIDTH-1:0] w1;
   logic [DATA_WIDTH-1:0] w2;

   // Kept one bit wider so an exact fit at the top of the
   // address space cannot wrap and admit further cells.
   logic [ADDR_WIDTH:0]   fp_x;

   logic [2:0]            req_len;
   logic [ADDR_WIDTH:0]   end_x;
   logic                  fire;
   logic [DATA_WIDTH-1:0] word_k;

   assign free_ptr = fp_x[ADDR_WIDTH-1:0];
   assign fire     = bus.req_valid && bus.req_ready;
   assign req_len  = cell_len(TAG_W'(bus.req_tag));
   assign end_x    = fp_x + AW1'(req_len);

   always_comb begin
      word_k = w2;
      unique case (k)
         3'd1:    word_k = w0;
         3'd2:    word_k = w1;
         default: word_k = w2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         base           <= '0;
         len            <= '0;
         k              <= '0;
         w0             <= '0;
         w1             <= '0;
         w2             <= '0;
         fp_x           <= BASE_X;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_addr  <= NIL_A;
         bus.resp_err   <= ERR_NONE;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fire) begin
                  bus.req_ready <= 1'b0;
                  w0            <= bus.req_w0;
                  w1            <= bus.req_w1;
                  w2            <= bus.req_w2;
                  len           <= req_len;
                  if (req_len == 3'd0) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_addr  <= NIL_A;
                     bus.resp_err   <= ERR_BAD_TAG;
                  end else if (end_x > LIMIT_P1) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_addr  <= NIL_A;
                     bus.resp_err   <= ERR_OOM;
                  end else begin
                     state     <= WRITE;
                     base      <= free_ptr;
                     k         <= 3'd1;
                     mem_we    <= 1'b1;
                     mem_addr  <= free_ptr;
                     mem_wdata <= bus.req_tag;
                  end
               end
            end
            WRITE: begin
               if (k == len) begin
                  state          <= RESP;
                  mem_we         <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.resp_addr  <= base;
                  bus.resp_err   <= ERR_NONE;
                  fp_x <= {1'b0, base} + AW1'(len);
               end else begin
                  mem_addr  <= base + ADDR_WIDTH'(k);
                  mem_wdata <= word_k;
                  k         <= k + 3'd1;
               end
            end
            RESP: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               mem_we        <= 1'b0;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
